// File: rtl/mem_stage_dual_pkg.sv
// rtl/mem_stage_dual_pkg.sv - shared types and widths for the dual-lane MEM stage
package mem_stage_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic {ST_RUN, ST_LANE2} state_t;
endpackage

// File: rtl/mem_stage_dual_if.sv
// rtl/mem_stage_dual_if.sv - EX/MEM lane inputs, stall and MEM/WB outputs of the MEM stage
interface mem_stage_dual_if;
  import mem_stage_pkg::*;

  logic [XLEN-1:0]  alu_1, alu_2;
  logic [XLEN-1:0]  wdata_1, wdata_2;
  logic [REG_W-1:0] rd_1, rd_2;
  logic             memread_1, memtoreg_1, memwrite_1, regwrite_1;
  logic             memread_2, memtoreg_2, memwrite_2, regwrite_2;
  logic             stall_o;
  logic [XLEN-1:0]  wb_alu_1, wb_alu_2;
  logic [XLEN-1:0]  wb_rdata_1, wb_rdata_2;
  logic [REG_W-1:0] wb_rd_1, wb_rd_2;
  logic             wb_memtoreg_1, wb_regwrite_1, wb_memtoreg_2, wb_regwrite_2;

  modport master (
    output alu_1, alu_2, wdata_1, wdata_2, rd_1, rd_2,
           memread_1, memtoreg_1, memwrite_1, regwrite_1,
           memread_2, memtoreg_2, memwrite_2, regwrite_2,
    input  stall_o, wb_alu_1, wb_alu_2, wb_rdata_1, wb_rdata_2, wb_rd_1, wb_rd_2,
           wb_memtoreg_1, wb_regwrite_1, wb_memtoreg_2, wb_regwrite_2
  );

  modport slave (
    input  alu_1, alu_2, wdata_1, wdata_2, rd_1, rd_2,
           memread_1, memtoreg_1, memwrite_1, regwrite_1,
           memread_2, memtoreg_2, memwrite_2, regwrite_2,
    output stall_o, wb_alu_1, wb_alu_2, wb_rdata_1, wb_rdata_2, wb_rd_1, wb_rd_2,
           wb_memtoreg_1, wb_regwrite_1, wb_memtoreg_2, wb_regwrite_2
  );
endinterface

// File: rtl/mem_stage_dual_dmem_sp.sv
// rtl/mem_stage_dual_dmem_sp.sv - single-port data RAM, combinational read, synchronous write
module dmem_sp
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read returns pre-write contents when a write to the same word lands this edge.
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage_dual.sv
// rtl/mem_stage_dual.sv - dual-lane MEM stage; serialises dual memory bundles over one RAM port
module mem_stage_dual
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_dual_if.slave bus
);
  state_t            state, state_next;
  logic [XLEN-1:0]   hold_rdata, mem_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, acc_1, acc_2, conflict, serve_1, stall;

  assign acc_1    = bus.memread_1 | bus.memwrite_1;
  assign acc_2    = bus.memread_2 | bus.memwrite_2;
  assign conflict = acc_1 & acc_2;

  always_comb begin
    state_next = state;
    serve_1    = 1'b0;
    case (state)
      ST_RUN: begin
        serve_1 = acc_1;
        if (conflict) state_next = ST_LANE2;
      end
      ST_LANE2: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
    stall = (state == ST_RUN) && conflict && !reset;
  end

  assign bus.stall_o = stall;
  assign mem_addr    = serve_1 ? bus.alu_1[ADDR_W+1:2] : bus.alu_2[ADDR_W+1:2];
  assign mem_wdata   = serve_1 ? bus.wdata_1 : bus.wdata_2;
  assign mem_we      = !reset && (serve_1 ? bus.memwrite_1 : bus.memwrite_2);

  dmem_sp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_RUN;
      hold_rdata        <= '0;
      bus.wb_alu_1      <= '0;
      bus.wb_alu_2      <= '0;
      bus.wb_rdata_1    <= '0;
      bus.wb_rdata_2    <= '0;
      bus.wb_rd_1       <= '0;
      bus.wb_rd_2       <= '0;
      bus.wb_memtoreg_1 <= 1'b0;
      bus.wb_regwrite_1 <= 1'b0;
      bus.wb_memtoreg_2 <= 1'b0;
      bus.wb_regwrite_2 <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_RUN && conflict) begin
        // First half of a conflicting bundle: park lane 1 load data, retire a bubble.
        hold_rdata        <= mem_rdata;
        bus.wb_alu_1      <= '0;
        bus.wb_alu_2      <= '0;
        bus.wb_rdata_1    <= '0;
        bus.wb_rdata_2    <= '0;
        bus.wb_rd_1       <= '0;
        bus.wb_rd_2       <= '0;
        bus.wb_memtoreg_1 <= 1'b0;
        bus.wb_regwrite_1 <= 1'b0;
        bus.wb_memtoreg_2 <= 1'b0;
        bus.wb_regwrite_2 <= 1'b0;
      end else begin
        bus.wb_alu_1      <= bus.alu_1;
        bus.wb_alu_2      <= bus.alu_2;
        bus.wb_rdata_1    <= (state == ST_LANE2) ? hold_rdata : (acc_1 ? mem_rdata : '0);
        bus.wb_rdata_2    <= acc_2 ? mem_rdata : '0;
        bus.wb_rd_1       <= bus.rd_1;
        bus.wb_rd_2       <= bus.rd_2;
        bus.wb_memtoreg_1 <= bus.memtoreg_1;
        bus.wb_regwrite_1 <= bus.regwrite_1;
        bus.wb_memtoreg_2 <= bus.memtoreg_2;
        bus.wb_regwrite_2 <= bus.regwrite_2;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_dual.sv
// tb/tb_mem_stage_dual.sv - randomized self-checking bench for mem_stage_dual
module tb_mem_stage_dual;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [31:0] alu1, alu2, wd1, wd2;
    logic [4:0]  rd1, rd2;
    logic        mr1, mt1, mw1, rw1, mr2, mt2, mw2, rw2;
  } bundle_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] ref_mem [DEPTH];

  mem_stage_dual_if bus();

  mem_stage_dual #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bundle_t idle_b();
    bundle_t b;
    b = '0;
    return b;
  endfunction

  function automatic bundle_t rand_b();
    bundle_t b;
    b.alu1 = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
    b.alu2 = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
    b.wd1 = $urandom;
    b.wd2 = $urandom;
    b.rd1 = 5'($urandom);
    b.rd2 = 5'($urandom);
    {b.mr1, b.mt1, b.mw1, b.rw1, b.mr2, b.mt2, b.mw2, b.rw2} = 8'($urandom);
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    bus.alu_1 = b.alu1;  bus.alu_2 = b.alu2;
    bus.wdata_1 = b.wd1; bus.wdata_2 = b.wd2;
    bus.rd_1 = b.rd1;    bus.rd_2 = b.rd2;
    bus.memread_1 = b.mr1; bus.memtoreg_1 = b.mt1; bus.memwrite_1 = b.mw1; bus.regwrite_1 = b.rw1;
    bus.memread_2 = b.mr2; bus.memtoreg_2 = b.mt2; bus.memwrite_2 = b.mw2; bus.regwrite_2 = b.rw2;
  endtask

  task automatic expect_wb(input bundle_t b, input logic [31:0] r1, input logic [31:0] r2,
                           input bit chk_rd);
    chk("wb_alu_1", bus.wb_alu_1, b.alu1);
    chk("wb_alu_2", bus.wb_alu_2, b.alu2);
    chk("wb_rd_1", 32'(bus.wb_rd_1), 32'(b.rd1));
    chk("wb_rd_2", 32'(bus.wb_rd_2), 32'(b.rd2));
    chk("wb_memtoreg_1", 32'(bus.wb_memtoreg_1), 32'(b.mt1));
    chk("wb_regwrite_1", 32'(bus.wb_regwrite_1), 32'(b.rw1));
    chk("wb_memtoreg_2", 32'(bus.wb_memtoreg_2), 32'(b.mt2));
    chk("wb_regwrite_2", 32'(bus.wb_regwrite_2), 32'(b.rw2));
    if (chk_rd) begin
      chk("wb_rdata_1", bus.wb_rdata_1, r1);
      chk("wb_rdata_2", bus.wb_rdata_2, r2);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the bundle retires.
  task automatic apply(input bundle_t b, input bit chk_rd);
    logic a1, a2, conf;
    int i1, i2;
    logic [31:0] r1, r2;
    drive(b);
    a1 = b.mr1 | b.mw1;
    a2 = b.mr2 | b.mw2;
    conf = a1 & a2;
    i1 = int'((b.alu1 >> 2) % DEPTH);
    i2 = int'((b.alu2 >> 2) % DEPTH);
    // Lane 1 takes effect on memory before lane 2; each read sees pre-write contents.
    r1 = a1 ? ref_mem[i1] : 32'h0;
    if (b.mw1) ref_mem[i1] = b.wd1;
    r2 = a2 ? ref_mem[i2] : 32'h0;
    if (b.mw2) ref_mem[i2] = b.wd2;
    #1 chk("stall", 32'(bus.stall_o), 32'(conf));
    if (conf) begin
      @(negedge clk);
      chk("bubble_regwrite_1", 32'(bus.wb_regwrite_1), 32'h0);
      chk("bubble_regwrite_2", 32'(bus.wb_regwrite_2), 32'h0);
      chk("bubble_memtoreg_1", 32'(bus.wb_memtoreg_1), 32'h0);
      chk("bubble_memtoreg_2", 32'(bus.wb_memtoreg_2), 32'h0);
      chk("stall_lane2", 32'(bus.stall_o), 32'h0);
    end
    @(negedge clk);
    expect_wb(b, r1, r2, chk_rd);
  endtask

  initial begin
    bundle_t b;

    // Reset with conflicting random inputs.
    b = rand_b();
    b.mr1 = 1'b1; b.mr2 = 1'b1;
    drive(b);
    @(negedge clk);
    #1 chk("reset_stall", 32'(bus.stall_o), 32'h0);
    @(negedge clk);
    expect_wb(idle_b(), 32'h0, 32'h0, 1'b1);
    reset = 1'b0;
    b = idle_b(); b.rw1 = 1'b1; b.alu1 = 32'h10; b.rd1 = 5'd3;
    apply(b, 1'b1);

    // Clear the RAM so the model starts from known contents.
    for (int i = 0; i < DEPTH; i++) begin
      b = idle_b(); b.mw1 = 1'b1; b.alu1 = 32'(i) << 2; b.wd1 = 32'h0;
      apply(b, 1'b0);
    end

    b = idle_b(); b.mw1 = 1'b1; b.alu1 = 32'h40; b.wd1 = 32'hDEADBEEF;
    apply(b, 1'b1);
    b = idle_b(); b.mr2 = 1'b1; b.mt2 = 1'b1; b.rw2 = 1'b1; b.alu2 = 32'h40; b.rd2 = 5'd7;
    apply(b, 1'b1);
    chk("store_then_load", bus.wb_rdata_2, 32'hDEADBEEF);

    b = idle_b(); b.mw1 = 1'b1; b.alu1 = 32'h80; b.wd1 = 32'h11111111;
    b.mr2 = 1'b1; b.alu2 = 32'h80; b.rw2 = 1'b1; b.mt2 = 1'b1;
    apply(b, 1'b1);
    chk("conflict_fwd", bus.wb_rdata_2, 32'h11111111);

    b = idle_b(); b.mw1 = 1'b1; b.alu1 = 32'h04; b.wd1 = 32'hA;
    apply(b, 1'b1);
    b = idle_b(); b.mw2 = 1'b1; b.alu2 = 32'h08; b.wd2 = 32'hB;
    apply(b, 1'b1);
    b = idle_b(); b.mr1 = 1'b1; b.alu1 = 32'h04; b.mr2 = 1'b1; b.alu2 = 32'h08;
    apply(b, 1'b1);
    chk("dual_load_1", bus.wb_rdata_1, 32'hA);
    chk("dual_load_2", bus.wb_rdata_2, 32'hB);

    b = idle_b(); b.mw1 = 1'b1; b.alu1 = 32'(4 * DEPTH + 8); b.wd1 = 32'hCAFE0008;
    apply(b, 1'b1);
    b = idle_b(); b.mr2 = 1'b1; b.alu2 = 32'h08;
    apply(b, 1'b1);
    chk("wrap_load", bus.wb_rdata_2, 32'hCAFE0008);

    b = idle_b(); b.mw1 = 1'b1; b.alu1 = 32'h0C; b.wd1 = 32'h1;
    b.mw2 = 1'b1; b.alu2 = 32'h0C; b.wd2 = 32'h2;
    apply(b, 1'b1);
    b = idle_b(); b.mr1 = 1'b1; b.alu1 = 32'h0C;
    apply(b, 1'b1);
    chk("dual_store", bus.wb_rdata_1, 32'h2);

    // Reset lands in the second cycle of a conflict: lane 2 store must be dropped.
    b = idle_b(); b.mr1 = 1'b1; b.alu1 = 32'h00;
    b.mw2 = 1'b1; b.alu2 = 32'h20; b.wd2 = 32'h55;
    drive(b);
    #1 chk("rst_conf_stall", 32'(bus.stall_o), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_lane2_stall", 32'(bus.stall_o), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(idle_b());
    expect_wb(idle_b(), 32'h0, 32'h0, 1'b1);
    #1 chk("post_rst_stall", 32'(bus.stall_o), 32'h0);
    @(negedge clk);
    b = idle_b(); b.mr1 = 1'b1; b.alu1 = 32'h20;
    apply(b, 1'b1);
    chk("rst_no_write", bus.wb_rdata_1, 32'h0);

    for (int n = 0; n < 400; n++) begin
      apply(rand_b(), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
